// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that gives one master at a time the shared
// slave bus. It routes the owner's control, write data, valid and last signals
// to the slaves, and returns the slave's read data and ready to the owner only.
//
// Handshake: m_req is a level request that the master holds for the whole
// transaction. Ownership ends when any one of these happens:
//   - the owner pulses m_done for one cycle,
//   - the owner drops m_req,
//   - the hold counter reaches TIMEOUT. A timeout exit pulses timeout_err.
// After ownership ends, the bus is idle for one RELEASE cycle before the next
// arbitration. Masters other than the owner always see m_rD = 0 and
// m_ready = 0. Their m_req and m_done have no effect on the current owner.
module bus_arbiter #(
  parameter int MASTERS = 2,
  parameter int TIMEOUT = 1023,
  parameter int OWN_W   = $clog2(MASTERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MASTERS-1:0] m_req,
  input  logic [MASTERS-1:0] m_done,
  input  logic [MASTERS-1:0] m_control,
  input  logic [MASTERS-1:0] m_wD,
  input  logic [MASTERS-1:0] m_valid,
  input  logic [MASTERS-1:0] m_last,
  output logic [MASTERS-1:0] m_grant,
  output logic [MASTERS-1:0] m_rD,
  output logic [MASTERS-1:0] m_ready,
  output logic               s_control,
  output logic               s_wD,
  output logic               s_valid,
  output logic               s_last,
  input  logic               s_rD,
  input  logic               s_ready,
  output logic [OWN_W-1:0]   owner,
  output logic               busy,
  output logic               timeout_err,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0]   TO_VAL   = (CNT_W + 1)'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(MASTERS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [OWN_W-1:0] rr_ptr;

  logic             win_found;
  logic [OWN_W-1:0] win_idx;
  logic [OWN_W-1:0] cand;
  logic [CNT_W:0]   cnt_plus;
  logic             timeout_hit;
  logic             own_end;

  assign state_dbg = state;
  assign busy      = |m_grant;

  // The hold counter counts completed BUSY cycles. The bus is released on
  // the edge that would make this count reach TIMEOUT.
  assign cnt_plus    = {1'b0, hold_cnt} + 1'b1;
  assign timeout_hit = (cnt_plus >= TO_VAL);
  assign own_end     = m_done[owner] | ~m_req[owner];

  // Round-robin search: take the first requester found starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < MASTERS; k++) begin
      cand = OWN_W'((int'(rr_ptr) + k) % MASTERS);
      if (!win_found && m_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Arbitration FSM. Grant, owner, hold counter and timeout pulse are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_grant     <= '0;
      owner       <= '0;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            m_grant  <= MASTERS'(1) << win_idx;
            owner    <= win_idx;
            hold_cnt <= '0;
            rr_ptr   <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          hold_cnt <= timeout_hit ? TO_CNT : cnt_plus[CNT_W-1:0];
          if (own_end || timeout_hit) begin
            // A done pulse or dropped request on the timeout edge is a normal end, not a timeout.
            timeout_err <= ~own_end;
            m_grant     <= '0;
            owner       <= '0;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          m_grant <= '0;
          owner   <= '0;
        end
      endcase
    end
  end

  // Bus routing: connect the owner to the slave bus. Everyone else sees zeros.
  always_comb begin
    s_control = 1'b0;
    s_wD      = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    m_rD      = '0;
    m_ready   = '0;
    if (state == BUSY) begin
      s_control      = m_control[owner];
      s_wD           = m_wD[owner];
      s_valid        = m_valid[owner];
      s_last         = m_last[owner];
      m_rD[owner]    = s_rD;
      m_ready[owner] = s_ready;
    end
  end

endmodule
